// File: rtl/conv_result_collector.sv
// Captures each accelerator result on the rising edge of cReady, rectifies/scales/saturates it,
// and streams it out of a small FIFO with row/frame position tags and back-pressure to the controller.
module conv_result_collector #(
    parameter int BIT_LENGTH = 16,
    parameter int OUT_WIDTH  = 8,
    parameter int SHIFT      = 4,
    parameter int FIFO_DEPTH = 8,
    parameter int ROW_LEN    = 6,
    parameter int ROW_COUNT  = 6
) (
    input  logic                  Clk,
    input  logic                  Rst_n,
    input  logic                  cReady,
    input  logic [BIT_LENGTH-1:0] finalsum,
    input  logic                  relu_en,
    output logic [OUT_WIDTH-1:0]  out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_last_row,
    output logic                  out_last_frame,
    output logic                  frame_done,
    output logic                  hold_off,
    output logic                  overflow,
    input  logic                  clear_err
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = (ROW_LEN > 1) ? $clog2(ROW_LEN) : 1;
    localparam int RW = (ROW_COUNT > 1) ? $clog2(ROW_COUNT) : 1;
    localparam int EW = OUT_WIDTH + 2;
    localparam int SAT_MAX_I = 2 ** (OUT_WIDTH - 1) - 1;
    localparam logic signed [BIT_LENGTH-1:0] SAT_MAX = BIT_LENGTH'(SAT_MAX_I);
    localparam logic signed [BIT_LENGTH-1:0] SAT_MIN = BIT_LENGTH'(-SAT_MAX_I - 1);

    logic                         cready_d;
    logic                         cap;
    logic [CW-1:0]                col;
    logic [RW-1:0]                row;
    logic                         last_row;
    logic                         last_frame;
    logic signed [BIT_LENGTH-1:0] rect;
    logic signed [BIT_LENGTH-1:0] shifted;
    logic [OUT_WIDTH-1:0]         sat;

    logic                         s1_valid;
    logic [EW-1:0]                s1_entry;

    logic [EW-1:0]                mem [FIFO_DEPTH];
    logic [AW-1:0]                wr_ptr;
    logic [AW-1:0]                rd_ptr;
    logic [AW:0]                  count;
    logic [AW:0]                  count_next;
    logic [EW-1:0]                head;
    logic                         full;
    logic                         pop;
    logic                         push_ok;
    logic                         drop;

    assign cap        = cReady & ~cready_d;
    assign last_row   = (col == CW'(ROW_LEN - 1));
    assign last_frame = last_row && (row == RW'(ROW_COUNT - 1));

    // Shift and clamp at full input width so the saturation sees the true magnitude
    always_comb begin
        rect    = (relu_en && finalsum[BIT_LENGTH-1]) ? '0 : finalsum;
        shifted = rect >>> SHIFT;
        sat     = shifted[OUT_WIDTH-1:0];
        if (shifted > SAT_MAX) begin
            sat = SAT_MAX[OUT_WIDTH-1:0];
        end else if (shifted < SAT_MIN) begin
            sat = SAT_MIN[OUT_WIDTH-1:0];
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            cready_d <= 1'b0;
            s1_valid <= 1'b0;
            s1_entry <= '0;
            col      <= '0;
            row      <= '0;
        end else begin
            cready_d <= cReady;
            s1_valid <= cap;
            if (cap) begin
                s1_entry <= {last_frame, last_row, sat};
                if (last_frame) begin
                    col <= '0;
                    row <= '0;
                end else if (last_row) begin
                    col <= '0;
                    row <= row + RW'(1);
                end else begin
                    col <= col + CW'(1);
                end
            end
        end
    end

    assign head      = mem[rd_ptr];
    assign out_valid = (count != '0);
    assign full      = (count == (AW + 1)'(FIFO_DEPTH));
    assign pop       = out_valid & out_ready;
    // A pop in the same cycle frees the slot, so a full FIFO can still take the write
    assign push_ok   = s1_valid & (~full | pop);
    assign drop      = s1_valid & ~push_ok;

    assign out_data       = out_valid ? head[OUT_WIDTH-1:0] : '0;
    assign out_last_row   = out_valid & head[OUT_WIDTH];
    assign out_last_frame = out_valid & head[OUT_WIDTH+1];

    always_comb begin
        count_next = count;
        if (push_ok && !pop) begin
            count_next = count + (AW + 1)'(1);
        end else if (pop && !push_ok) begin
            count_next = count - (AW + 1)'(1);
        end
    end

    always_ff @(posedge Clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= s1_entry;
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            hold_off   <= 1'b0;
            frame_done <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count      <= count_next;
            hold_off   <= (count_next >= (AW + 1)'(FIFO_DEPTH - 2));
            frame_done <= pop & head[OUT_WIDTH+1];
            if (drop) begin
                overflow <= 1'b1;
            end else if (clear_err) begin
                overflow <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_conv_result_collector.sv
// Self-checking bench for conv_result_collector: a queue-based reference model is checked every cycle,
// plus table vectors and directed sequences for latency, framing, overflow and reset.
module tb_conv_result_collector;

    logic        Clk = 1'b0;
    logic        Rst_n;
    logic        cReady;
    logic [15:0] finalsum;
    logic        relu_en;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic        out_last_row;
    logic        out_last_frame;
    logic        frame_done;
    logic        hold_off;
    logic        overflow;
    logic        clear_err;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state: queue of {last_frame, last_row, data}
    logic [9:0] q[$];
    bit         m_pend;
    logic [9:0] m_pend_e;
    int         m_col, m_row;
    bit         m_cd, m_ovf, m_fd, m_hold;

    typedef struct {
        logic [15:0] fs;
        logic        relu;
        logic [7:0]  exp;
    } vec_t;
    vec_t vecs[7];

    conv_result_collector dut (
        .Clk(Clk), .Rst_n(Rst_n), .cReady(cReady), .finalsum(finalsum), .relu_en(relu_en),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_last_row(out_last_row), .out_last_frame(out_last_frame), .frame_done(frame_done),
        .hold_off(hold_off), .overflow(overflow), .clear_err(clear_err)
    );

    always #5 Clk = ~Clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    function automatic logic [9:0] model_result(logic [15:0] fs, logic relu, int col, int row);
        int         v;
        logic [7:0] d;
        bit         lr, lf;
        v = int'($signed(fs));
        if (relu && v < 0) v = 0;
        v = v >>> 4;
        if (v > 127) v = 127;
        if (v < -128) v = -128;
        d  = 8'(v);
        lr = (col == 5);
        lf = lr && (row == 5);
        return {lf, lr, d};
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_pend = 0; m_pend_e = '0; m_col = 0; m_row = 0;
        m_cd = 0; m_ovf = 0; m_fd = 0; m_hold = 0;
    endtask

    // Drive one cycle of inputs, advance the model over the clock edge, then compare everything
    task automatic applyStimulus(input logic cr, input logic [15:0] fs, input logic relu,
                                 input logic rdy, input logic clr);
        bit         pop, pop_lf;
        logic [9:0] popped;
        cReady = cr; finalsum = fs; relu_en = relu; out_ready = rdy; clear_err = clr;
        @(posedge Clk);
        pop    = (q.size() > 0) && rdy;
        pop_lf = 0;
        if (pop) begin
            popped = q.pop_front();
            pop_lf = popped[9];
        end
        m_fd = pop_lf;
        if (m_pend && q.size() >= 8) m_ovf = 1;
        else if (clr) m_ovf = 0;
        if (m_pend && q.size() < 8) q.push_back(m_pend_e);
        m_hold = (q.size() >= 6);
        m_pend = cr && !m_cd;
        if (m_pend) begin
            m_pend_e = model_result(fs, relu, m_col, m_row);
            if (m_col == 5) begin
                m_col = 0;
                m_row = (m_row == 5) ? 0 : m_row + 1;
            end else begin
                m_col++;
            end
        end
        m_cd = cr;
        #1;
        checkOutput("cyc_valid", 32'(out_valid), 32'(q.size() > 0));
        if (q.size() > 0 && out_valid)
            checkOutput("cyc_head", {22'd0, out_last_frame, out_last_row, out_data}, 32'(q[0]));
        checkOutput("cyc_flags", {29'd0, hold_off, overflow, frame_done}, {29'd0, m_hold, m_ovf, m_fd});
    endtask

    task automatic pulse(input logic [15:0] fs, input logic relu, input logic rdy);
        applyStimulus(1'b1, fs, relu, rdy, 1'b0);
        applyStimulus(1'b0, fs, relu, rdy, 1'b0);
    endtask

    // Asynchronous reset asserted between clock edges
    task automatic do_reset();
        #2;
        Rst_n = 1'b0;
        cReady = 1'b0; clear_err = 1'b0;
        #1;
        checkOutput("reset_outs",
                    {17'd0, out_valid, out_data, out_last_row, out_last_frame, frame_done, hold_off, overflow},
                    32'd0);
        model_reset();
        @(posedge Clk);
        #1;
        Rst_n = 1'b1;
    endtask

    initial begin
        Rst_n = 1'b0; cReady = 0; finalsum = '0; relu_en = 0; out_ready = 0; clear_err = 0;
        model_reset();
        vecs[0] = '{16'h0123, 1'b0, 8'h12};
        vecs[1] = '{16'h7FFF, 1'b0, 8'h7F};
        vecs[2] = '{16'h8000, 1'b0, 8'h80};
        vecs[3] = '{16'hFF00, 1'b0, 8'hF0};
        vecs[4] = '{16'hFF00, 1'b1, 8'h00};
        vecs[5] = '{16'hFFFF, 1'b0, 8'hFF};
        vecs[6] = '{16'h07F0, 1'b1, 8'h7F};
        @(posedge Clk);
        #1;
        do_reset();

        $display("[TB] latency");
        applyStimulus(1'b1, 16'h0123, 1'b0, 1'b1, 1'b0);
        checkOutput("lat_edge_k", 32'(out_valid), 32'd0);
        applyStimulus(1'b0, 16'h0123, 1'b0, 1'b1, 1'b0);
        checkOutput("lat_edge_k1_valid", 32'(out_valid), 32'd1);
        checkOutput("lat_edge_k1_data", 32'(out_data), 32'h12);
        applyStimulus(1'b0, 16'h0, 1'b0, 1'b1, 1'b0);
        checkOutput("lat_one_cycle", 32'(out_valid), 32'd0);

        $display("[TB] table vectors");
        do_reset();
        for (int i = 0; i < 7; i++) begin
            applyStimulus(1'b1, vecs[i].fs, vecs[i].relu, 1'b1, 1'b0);
            applyStimulus(1'b0, vecs[i].fs, vecs[i].relu, 1'b1, 1'b0);
            for (int w = 0; w < 4 && !out_valid; w++)
                applyStimulus(1'b0, 16'h0, 1'b0, 1'b1, 1'b0);
            checkOutput($sformatf("vec%0d_valid", i), 32'(out_valid), 32'd1);
            checkOutput($sformatf("vec%0d_data", i), 32'(out_data), 32'(vecs[i].exp));
            applyStimulus(1'b0, 16'h0, 1'b0, 1'b1, 1'b0);
        end

        $display("[TB] held cReady");
        do_reset();
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 16'h0100, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 2; i++) applyStimulus(1'b0, 16'h0100, 1'b0, 1'b0, 1'b0);
        checkOutput("held_has_entry", 32'(out_valid), 32'd1);
        applyStimulus(1'b0, 16'h0, 1'b0, 1'b1, 1'b0);
        checkOutput("held_single_entry", 32'(out_valid), 32'd0);

        $display("[TB] frame tags");
        do_reset();
        for (int p = 1; p <= 37; p++) begin
            applyStimulus(1'b1, 16'(p * 16), 1'b0, 1'b1, 1'b0);
            if (p == 37) checkOutput("frame_done_pulse", 32'(frame_done), 32'd1);
            applyStimulus(1'b0, 16'(p * 16), 1'b0, 1'b1, 1'b0);
            checkOutput($sformatf("frame_tags_%0d", p), {30'd0, out_last_frame, out_last_row},
                        {30'd0, (p == 36), (p % 6 == 0)});
        end
        applyStimulus(1'b0, 16'h0, 1'b0, 1'b1, 1'b0);

        $display("[TB] hold_off and overflow");
        do_reset();
        for (int p = 1; p <= 8; p++) begin
            pulse(16'(p * 16), 1'b0, 1'b0);
            if (p == 5) checkOutput("hold_off_occ5", 32'(hold_off), 32'd0);
            if (p == 6) checkOutput("hold_off_occ6", 32'(hold_off), 32'd1);
            if (p == 8) checkOutput("no_ovf_at_full", 32'(overflow), 32'd0);
        end
        applyStimulus(1'b1, 16'h0090, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 16'h0090, 1'b0, 1'b0, 1'b1);
        checkOutput("ovf_set_wins", 32'(overflow), 32'd1);
        for (int i = 1; i <= 8; i++) begin
            checkOutput($sformatf("fifo_order_%0d", i), 32'(out_data), 32'(i));
            applyStimulus(1'b0, 16'h0, 1'b0, 1'b1, 1'b0);
        end
        checkOutput("drained", 32'(out_valid), 32'd0);
        applyStimulus(1'b0, 16'h0, 1'b0, 1'b0, 1'b1);
        checkOutput("ovf_cleared", 32'(overflow), 32'd0);

        $display("[TB] full push+pop and mid-frame reset");
        do_reset();
        for (int p = 1; p <= 8; p++) pulse(16'(p * 16), 1'b0, 1'b0);
        applyStimulus(1'b1, 16'h0200, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 16'h0200, 1'b0, 1'b1, 1'b0);
        checkOutput("full_pushpop_ovf", 32'(overflow), 32'd0);
        checkOutput("full_pushpop_hold", 32'(hold_off), 32'd1);
        applyStimulus(1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
        checkOutput("full_pushpop_head", 32'(out_data), 32'd2);
        do_reset();
        for (int p = 1; p <= 6; p++) begin
            pulse(16'h0010, 1'b0, 1'b1);
            if (p == 6) checkOutput("post_reset_tags", 32'(out_last_row), 32'd1);
        end
        applyStimulus(1'b0, 16'h0, 1'b0, 1'b1, 1'b0);

        $display("[TB] random");
        do_reset();
        for (int i = 0; i < 600; i++) begin
            logic rdy;
            rdy = (i < 300) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
            applyStimulus(1'($urandom_range(0, 1)), 16'($urandom), 1'($urandom_range(0, 1)),
                          rdy, ($urandom_range(0, 15) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
